// File: rtl/first_nios2_system_sysid_pkg.sv
// Shared definitions for the system-ID checker and the slave's bench model:
// FSM state encoding, slave word addresses and the default expected values.
package first_nios2_system_sysid_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ_ID = 2'd1,
        READ_TS = 2'd2,
        DONE    = 2'd3
    } sysid_state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_DEFAULT_ID        = 32'd7;
    localparam logic [31:0] SYSID_DEFAULT_TIMESTAMP = 32'd1384440210;

endpackage

// File: rtl/first_nios2_system_sysid_checker.sv
// Avalon-MM read master that fetches the system-ID and timestamp words,
// compares them with build-time values and keeps a saturating failure count.
module first_nios2_system_sysid_checker
    import first_nios2_system_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TIMESTAMP,
    parameter int          READ_LATENCY       = 0,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    output logic [31:0] id_value,
    output logic [31:0] timestamp_value,
    output logic        busy,
    output logic        done,
    output logic        match,
    output logic [7:0]  mismatch_count
);

    // Last latency count of a word read; data is sampled on that cycle.
    localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY);

    sysid_state_t state;
    sysid_state_t state_next;
    logic [1:0]   lat_cnt;
    logic         capture;
    logic         check_ok;

    // Next-state decode plus the bus strobes and status flags derived from state
    always_comb begin
        state_next  = state;
        avm_read    = 1'b0;
        avm_address = SYSID_ADDR_ID;
        busy        = 1'b0;
        done        = 1'b0;
        capture     = (lat_cnt == LAT_LAST);
        check_ok    = (id_value == EXPECTED_ID) &&
                      (avm_readdata == EXPECTED_TIMESTAMP);
        case (state)
            IDLE: begin
                if (AUTO_START || start) begin
                    state_next = READ_ID;
                end
            end
            READ_ID: begin
                busy        = 1'b1;
                avm_address = SYSID_ADDR_ID;
                avm_read    = (lat_cnt == 2'd0);
                if (capture) begin
                    state_next = READ_TS;
                end
            end
            READ_TS: begin
                busy        = 1'b1;
                avm_address = SYSID_ADDR_TS;
                avm_read    = (lat_cnt == 2'd0);
                if (capture) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = READ_ID;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and per-word latency counter, cleared between words
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            lat_cnt <= 2'd0;
        end else begin
            state <= state_next;
            if (busy && !capture) begin
                lat_cnt <= lat_cnt + 2'd1;
            end else begin
                lat_cnt <= 2'd0;
            end
        end
    end

    // Capture read data and score the check when the timestamp arrives
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            id_value        <= 32'd0;
            timestamp_value <= 32'd0;
            match           <= 1'b0;
            mismatch_count  <= 8'd0;
        end else begin
            if (state == READ_ID && capture) begin
                id_value <= avm_readdata;
            end
            if (state == READ_TS && capture) begin
                timestamp_value <= avm_readdata;
                match           <= check_ok;
                if (!check_ok && mismatch_count != 8'hFF) begin
                    mismatch_count <= mismatch_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// Bench for the system-ID checker: three instances (latency 0 auto, latency 2
// auto, latency 1 manual start) each talking to a behavioural slave model.
module tb_first_nios2_system_sysid_checker;

    localparam int N = 3;
    localparam logic [31:0] EXP_ID = 32'd7;
    localparam logic [31:0] EXP_TS = 32'd1384440210;

    logic        clock = 1'b0;
    logic        reset;
    logic        start           [N];
    logic        avm_read        [N];
    logic        avm_address     [N];
    logic        busy            [N];
    logic        done            [N];
    logic        match           [N];
    logic [31:0] id_value        [N];
    logic [31:0] timestamp_value [N];
    logic [7:0]  mismatch_count  [N];
    logic [31:0] id_word         [N];
    logic [31:0] ts_word         [N];

    int          checks = 0;
    int          errors = 0;
    int          exp_count [N];
    logic [31:0] exp_id    [N];
    logic [31:0] exp_ts    [N];
    logic        exp_match [N];

    always #5 clock = ~clock;

    function automatic int lat_of(input int g);
        return (g == 1) ? 2 : (g == 2) ? 1 : 0;
    endfunction

    generate
        for (genvar g = 0; g < N; g++) begin : gen_sys
            localparam int L = (g == 1) ? 2 : (g == 2) ? 1 : 0;
            logic [2:0]  pv;
            logic [2:0]  pa;
            logic [31:0] garbage;
            logic [31:0] rdata;
            logic        v;
            logic        a;

            // Slave model: remember each issued read and its address
            always @(posedge clock or posedge reset) begin
                if (reset) begin
                    pv <= 3'd0;
                    pa <= 3'd0;
                end else begin
                    pv <= {pv[1:0], avm_read[g]};
                    pa <= {pa[1:0], avm_address[g]};
                end
            end

            // Junk on the data bus whenever no read result is due
            always @(posedge clock) garbage <= $urandom;

            // Present the addressed word exactly L cycles after the read strobe
            always_comb begin
                if (L == 0) begin
                    v = avm_read[g];
                    a = avm_address[g];
                end else begin
                    v = pv[(L == 0) ? 0 : L - 1];
                    a = pa[(L == 0) ? 0 : L - 1];
                end
                rdata = v ? (a ? ts_word[g] : id_word[g]) : garbage;
            end

            first_nios2_system_sysid_checker #(
                .EXPECTED_ID        (EXP_ID),
                .EXPECTED_TIMESTAMP (EXP_TS),
                .READ_LATENCY       (L),
                .AUTO_START         (g != 2)
            ) dut (
                .clock           (clock),
                .reset           (reset),
                .start           (start[g]),
                .avm_address     (avm_address[g]),
                .avm_read        (avm_read[g]),
                .avm_readdata    (rdata),
                .id_value        (id_value[g]),
                .timestamp_value (timestamp_value[g]),
                .busy            (busy[g]),
                .done            (done[g]),
                .match           (match[g]),
                .mismatch_count  (mismatch_count[g])
            );
        end
    endgenerate

    task automatic model_reset();
        for (int g = 0; g < N; g++) begin
            exp_count[g] = 0;
            exp_id[g]    = 32'd0;
            exp_ts[g]    = 32'd0;
            exp_match[g] = 1'b0;
        end
    endtask

    // One completed check: results follow the slave's words, failures saturate at 255
    task automatic model_check(input int g);
        exp_id[g]    = id_word[g];
        exp_ts[g]    = ts_word[g];
        exp_match[g] = (id_word[g] == EXP_ID) && (ts_word[g] == EXP_TS);
        if (!exp_match[g]) begin
            exp_count[g] = (exp_count[g] >= 255) ? 255 : exp_count[g] + 1;
        end
    endtask

    task automatic check_zero(input string tag);
        for (int g = 0; g < N; g++) begin
            checks++;
            if ({busy[g], done[g], match[g], avm_read[g], avm_address[g]} !== 5'b0 ||
                id_value[g] !== 32'd0 || timestamp_value[g] !== 32'd0 ||
                mismatch_count[g] !== 8'd0) begin
                errors++;
                $display("[TB] FAIL %s inst%0d got flags=%b id=%0h ts=%0h cnt=%0d want all zero",
                         tag, g, {busy[g], done[g], match[g], avm_read[g], avm_address[g]},
                         id_value[g], timestamp_value[g], mismatch_count[g]);
            end
        end
    endtask

    // Observe 13 edges starting at the next rising edge (the trigger edge),
    // then check read pulses, done timing and captured results per instance
    task automatic watch(input logic [N-1:0] act, input int pulse_g, input int pulse_n,
                         input string tag);
        int nrd [N];
        int rdn [N][2];
        int rda [N][2];
        int dn  [N];
        int lat;
        for (int g = 0; g < N; g++) begin
            nrd[g] = 0;
            dn[g]  = -1;
            for (int k = 0; k < 2; k++) begin
                rdn[g][k] = -1;
                rda[g][k] = -1;
            end
        end
        for (int n = 0; n <= 12; n++) begin
            @(posedge clock);
            @(negedge clock);
            for (int g = 0; g < N; g++) start[g] = 1'b0;
            if (n == pulse_n) start[pulse_g] = 1'b1;
            for (int g = 0; g < N; g++) begin
                if (avm_read[g]) begin
                    if (nrd[g] < 2) begin
                        rdn[g][nrd[g]] = n;
                        rda[g][nrd[g]] = int'(avm_address[g]);
                    end
                    nrd[g]++;
                end
                if (done[g] && dn[g] < 0) dn[g] = n;
            end
        end
        for (int g = 0; g < N; g++) begin
            lat = lat_of(g);
            if (act[g]) begin
                model_check(g);
                checks++;
                if (nrd[g] != 2 || rdn[g][0] != 0 || rda[g][0] != 0 ||
                    rdn[g][1] != lat + 1 || rda[g][1] != 1) begin
                    errors++;
                    $display("[TB] FAIL %s_reads inst%0d got %0d reads at %0d/%0d addr %0d/%0d want 2 at 0/%0d addr 0/1",
                             tag, g, nrd[g], rdn[g][0], rdn[g][1], rda[g][0], rda[g][1], lat + 1);
                end
                checks++;
                if (dn[g] != 2 * (lat + 1)) begin
                    errors++;
                    $display("[TB] FAIL %s_done_edge inst%0d got %0d want %0d",
                             tag, g, dn[g], 2 * (lat + 1));
                end
            end else begin
                checks++;
                if (nrd[g] != 0) begin
                    errors++;
                    $display("[TB] FAIL %s_idle_reads inst%0d got %0d want 0", tag, g, nrd[g]);
                end
            end
            checks++;
            if (id_value[g] !== exp_id[g]) begin
                errors++;
                $display("[TB] FAIL %s_id inst%0d got %0h want %0h", tag, g, id_value[g], exp_id[g]);
            end
            checks++;
            if (timestamp_value[g] !== exp_ts[g]) begin
                errors++;
                $display("[TB] FAIL %s_ts inst%0d got %0h want %0h", tag, g, timestamp_value[g], exp_ts[g]);
            end
            checks++;
            if (match[g] !== exp_match[g]) begin
                errors++;
                $display("[TB] FAIL %s_match inst%0d got %b want %b", tag, g, match[g], exp_match[g]);
            end
            checks++;
            if (mismatch_count[g] !== 8'(exp_count[g])) begin
                errors++;
                $display("[TB] FAIL %s_count inst%0d got %0d want %0d", tag, g, mismatch_count[g], exp_count[g]);
            end
        end
    endtask

    function automatic logic [31:0] pick_word(input logic [31:0] good, input bit wrong);
        logic [31:0] w;
        if (!wrong) return good;
        w = $urandom;
        if (w == good) w = w ^ 32'd1;
        return w;
    endfunction

    task automatic test_reset();
        model_reset();
        for (int g = 0; g < N; g++) begin
            start[g]   = 1'b0;
            id_word[g] = EXP_ID;
            ts_word[g] = EXP_TS;
        end
        reset = 1'b1;
        repeat (5) @(posedge clock);
        @(negedge clock);
        check_zero("reset");
        reset = 1'b0;
        watch(3'b011, 0, -1, "auto");
        start[2] = 1'b1;
        watch(3'b100, 0, -1, "manual");
    endtask

    task automatic test_mismatch();
        id_word[0] = 32'd8;
        ts_word[0] = EXP_TS;
        start[0]   = 1'b1;
        watch(3'b001, 0, -1, "mismatch1");
        start[0]   = 1'b1;
        watch(3'b001, 0, -1, "mismatch2");
    endtask

    task automatic test_start_busy();
        id_word[1] = EXP_ID;
        ts_word[1] = EXP_TS;
        start[1]   = 1'b1;
        watch(3'b010, 1, 4, "busy_start");
    endtask

    task automatic test_random();
        int kind;
        for (int it = 0; it < 15; it++) begin
            for (int g = 0; g < N; g++) begin
                kind       = int'($urandom_range(0, 3));
                id_word[g] = pick_word(EXP_ID, kind == 1 || kind == 3);
                ts_word[g] = pick_word(EXP_TS, kind == 2 || kind == 3);
                start[g]   = 1'b1;
            end
            watch(3'b111, 0, -1, "random");
        end
    endtask

    task automatic test_saturation();
        id_word[0] = 32'd9;
        ts_word[0] = EXP_TS;
        for (int it = 0; it < 300; it++) begin
            @(negedge clock);
            start[0] = 1'b1;
            @(posedge clock);
            @(negedge clock);
            start[0] = 1'b0;
            repeat (2) @(posedge clock);
            @(negedge clock);
            model_check(0);
            checks++;
            if (mismatch_count[0] !== 8'(exp_count[0]) || done[0] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL saturate it%0d got cnt=%0d done=%b want cnt=%0d done=1",
                         it, mismatch_count[0], done[0], exp_count[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        for (int g = 0; g < N; g++) start[g] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        for (int g = 0; g < N; g++) start[g] = 1'b0;
        repeat (3) begin
            @(posedge clock);
            @(negedge clock);
        end
        checks++;
        if (busy[1] !== 1'b1 || busy[2] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_busy got %b%b want 11", busy[1], busy[2]);
        end
        #2 reset = 1'b1;
        #1 check_zero("reset_mid");
        model_reset();
        for (int g = 0; g < N; g++) begin
            id_word[g] = EXP_ID;
            ts_word[g] = EXP_TS;
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        watch(3'b011, 0, -1, "after_reset");
        start[2] = 1'b1;
        watch(3'b100, 0, -1, "after_reset_manual");
    endtask

    // Run every scenario in order, then report
    initial begin
        for (int g = 0; g < N; g++) start[g] = 1'b0;
        reset = 1'b1;
        test_reset();
        test_mismatch();
        test_start_busy();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
